// File: rtl/dsp_mac_speed.sv
// dsp_mac_speed: Fmax harness with byte-fed operand registers, NUM_CH pipelined MAC lanes and an XOR-reduced output.
// Ports: clk, reset (sync, active-high), cke (global enable), a/b (operand byte streams),
//        in_valid/acc_clr/mode (sample flags captured with the byte shift), p (XOR of all lane outputs),
//        out_valid (out_p holds a result from a valid sample).
// Optional macro: DSP_MAC_SATURATE_EN makes the MAC add clamp to the accumulator range instead of wrapping.
module dsp_mac_speed #(
    parameter int LATENCY  = 6,
    parameter int A_BITS   = 32,
    parameter int B_BITS   = 32,
    parameter int ACC_BITS = 72,
    parameter int NUM_CH   = 2,
    parameter int SIGNED   = 1,
    parameter int SHIFT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cke,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       in_valid,
    input  logic       acc_clr,
    input  logic       mode,
    output logic       p,
    output logic       out_valid
);
    localparam int P = A_BITS + B_BITS;

    (* dont_touch = "true" *) logic [A_BITS-1:0] in_a;
    (* dont_touch = "true" *) logic [B_BITS-1:0] in_b;
    logic               s_v, s_c, s_m;
    logic [A_BITS-1:0]  st_a;
    logic [LATENCY-1:0] v_pipe, c_pipe, md_pipe;
    logic               acc_v;
    logic [NUM_CH-1:0]  lane_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_a      <= '0;
            in_b      <= '0;
            s_v       <= 1'b0;
            s_c       <= 1'b0;
            s_m       <= 1'b0;
            st_a      <= '0;
            v_pipe    <= '0;
            c_pipe    <= '0;
            md_pipe   <= '0;
            acc_v     <= 1'b0;
            out_valid <= 1'b0;
        end else if (cke) begin
            in_a      <= A_BITS'({in_a, a});
            in_b      <= B_BITS'({in_b, b});
            s_v       <= in_valid;
            s_c       <= acc_clr;
            s_m       <= mode;
            st_a      <= in_a;
            v_pipe    <= {v_pipe[LATENCY-2:0], s_v};
            c_pipe    <= {c_pipe[LATENCY-2:0], s_c};
            md_pipe   <= {md_pipe[LATENCY-2:0], s_m};
            acc_v     <= v_pipe[LATENCY-1];
            out_valid <= acc_v;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        localparam int R = (8 * k) % B_BITS;
        logic [B_BITS-1:0]   st_b, rot;
        logic [P-1:0]        xa, xb, last;
        logic [P-1:0]        m_pipe [LATENCY-1];
        logic [ACC_BITS-1:0] acc, out_p, em, nxt, sh;
`ifdef DSP_MAC_SATURATE_EN
        localparam logic [ACC_BITS-1:0] ALL1 = '1;
        localparam logic [ACC_BITS-1:0] SMAX = ALL1 >> 1;
        localparam logic [ACC_BITS-1:0] SMIN = ~SMAX;
        logic [ACC_BITS:0] sum;
        logic              ovf;
`endif
        always_comb begin
            rot  = B_BITS'({in_b, in_b} >> (B_BITS - R));
            // Operands are widened to the product width first so one unsigned multiply serves both signed modes.
            xa   = {{B_BITS{SIGNED != 0 && st_a[A_BITS-1]}}, st_a};
            xb   = {{A_BITS{SIGNED != 0 && st_b[B_BITS-1]}}, st_b};
            last = m_pipe[LATENCY-2];
            em   = ACC_BITS'({{ACC_BITS{SIGNED != 0 && last[P-1]}}, last});
`ifdef DSP_MAC_SATURATE_EN
            sum  = {1'b0, acc} + {1'b0, em};
            ovf  = acc[ACC_BITS-1] == em[ACC_BITS-1] && sum[ACC_BITS-1] != acc[ACC_BITS-1];
            nxt  = SIGNED != 0 ? (ovf ? (em[ACC_BITS-1] ? SMIN : SMAX) : sum[ACC_BITS-1:0])
                               : (sum[ACC_BITS] ? ALL1 : sum[ACC_BITS-1:0]);
`else
            nxt  = acc + em;
`endif
            sh   = SIGNED != 0 ? ACC_BITS'({{ACC_BITS{acc[ACC_BITS-1]}}, acc} >> SHIFT) : acc >> SHIFT;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st_b  <= '0;
                for (int j = 0; j < LATENCY-1; j++) m_pipe[j] <= '0;
                acc   <= '0;
                out_p <= '0;
            end else if (cke) begin
                st_b      <= rot;
                m_pipe[0] <= xa * xb;
                for (int j = 1; j < LATENCY-1; j++) m_pipe[j] <= m_pipe[j-1];
                if (v_pipe[LATENCY-1])
                    acc <= (md_pipe[LATENCY-1] && !c_pipe[LATENCY-1]) ? nxt : em;
                else if (c_pipe[LATENCY-1])
                    acc <= '0;
                out_p <= sh;
            end
        end

        assign lane_x[k] = ^out_p;
    end

    assign p = ^lane_x;
endmodule

// File: tb/tb_dsp_mac_speed.sv
// tb_dsp_mac_speed: directed self-checking bench for dsp_mac_speed (8x8 signed, 24-bit acc, LATENCY 4, one lane).
module tb_dsp_mac_speed;
    logic        clk = 1'b0, reset = 1'b1, cke = 1'b1;
    logic        in_valid = 1'b0, acc_clr = 1'b0, mode = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        p, out_valid;
    logic [23:0] out_p;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dsp_mac_speed #(
        .LATENCY(4), .A_BITS(8), .B_BITS(8), .ACC_BITS(24),
        .NUM_CH(1), .SIGNED(1), .SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke), .a(a), .b(b),
        .in_valid(in_valid), .acc_clr(acc_clr), .mode(mode),
        .p(p), .out_valid(out_valid)
    );

    assign out_p = dut.g_lane[0].out_p;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++;
        if (p !== 1'b0) begin n_bad++; $display("FAIL reset_p got %b want 0", p); end
        n_cmp++;
        if (out_p !== 24'h0) begin n_bad++; $display("FAIL reset_out_p got %h want 000000", out_p); end
    endtask

    task automatic test_multiply;
        a = 8'hFD; b = 8'h07; mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_early_valid edge+%0d got %b want 0", i, out_valid); end
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mul_valid got %b want 1", out_valid); end
        n_cmp++;
        if (out_p !== 24'hFFFFEB) begin n_bad++; $display("FAIL mul_out_p got %h want ffffeb", out_p); end
        n_cmp++;
        if (p !== 1'b0) begin n_bad++; $display("FAIL mul_p got %b want 0", p); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_pulse_end got %b want 0", out_valid); end
        n_cmp++;
        if (out_p !== 24'hFFFFEB) begin n_bad++; $display("FAIL mul_hold got %h want ffffeb", out_p); end
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (out_p !== 24'h0) begin n_bad++; $display("FAIL clr_idle got %h want 000000", out_p); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_mac;
        logic [23:0] exp;
        a = 8'd100; b = 8'd100; mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_clr = (i == 0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; acc_clr = 1'b0;
        repeat (3) tick();
        for (int i = 1; i <= 4; i++) begin
            exp = 24'(10000 * i);
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mac_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++;
            if (out_p !== exp) begin n_bad++; $display("FAIL mac_out_p[%0d] got %0d want %0d", i, out_p, exp); end
            n_cmp++;
            if (p !== ^exp) begin n_bad++; $display("FAIL mac_p[%0d] got %b want %b", i, p, ^exp); end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mac_tail got %b want 0", out_valid); end
    endtask

    task automatic test_wrap_saturate;
        int          cnt;
        logic [23:0] exp;
`ifdef DSP_MAC_SATURATE_EN
        localparam logic [23:0] AT512 = 24'h7FFFFF, AT600 = 24'h7FFFFF;
`else
        localparam logic [23:0] AT512 = 24'h800000, AT600 = 24'h960000;
`endif
        a = 8'h80; b = 8'h80; mode = 1'b1;
        for (int t = 0; t < 606; t++) begin
            in_valid = (t < 600);
            acc_clr  = (t == 0);
            tick();
            cnt = t - 5;
            if (cnt == 200 || cnt == 511 || cnt == 512 || cnt == 600) begin
                exp = cnt == 200 ? 24'h320000 : cnt == 511 ? 24'h7FC000 : cnt == 512 ? AT512 : AT600;
                n_cmp++;
                if (out_p !== exp) begin n_bad++; $display("FAIL stream_out_p[%0d] got %h want %h", cnt, out_p, exp); end
                n_cmp++;
                if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", cnt, out_valid); end
            end
        end
        in_valid = 1'b0; acc_clr = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_tail got %b want 0", out_valid); end
    endtask

    task automatic test_cke_gap;
        int c = 0, ns = 0, s;
        a = 8'd2; b = 8'd3; mode = 1'b1;
        for (int t = 0; t < 22; t++) begin
            cke      = !(t >= 8 && t <= 10);
            in_valid = (ns < 10);
            acc_clr  = (ns == 0);
            tick();
            if (cke) begin
                if (in_valid) ns++;
                c++;
            end
            s = c - 7;
            if (s >= 0 && s < 10) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_p !== 24'(6 * (s + 1)))
                    begin n_bad++; $display("FAIL cke_run t=%0d got v=%b %0d want v=1 %0d", t, out_valid, out_p, 6 * (s + 1)); end
            end else if (s >= 10) begin
                n_cmp++;
                if (out_valid !== 1'b0 || out_p !== 24'd60)
                    begin n_bad++; $display("FAIL cke_tail t=%0d got v=%b %0d want v=0 60", t, out_valid, out_p); end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cke_head t=%0d got v=%b want 0", t, out_valid); end
            end
        end
        cke = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        a = 8'd100; b = 8'd100; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            acc_clr  = (i == 0);
            tick();
        end
        in_valid = 1'b0; acc_clr = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out_p !== 24'h0) begin n_bad++; $display("FAIL rst_mid_out_p got %h want 000000", out_p); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || p !== 1'b0)
                begin n_bad++; $display("FAIL rst_mid_stale[%0d] got v=%b p=%b want 0 0", i, out_valid, p); end
            tick();
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_resume_valid got %b want 1", out_valid); end
        n_cmp++;
        if (out_p !== 24'd10000) begin n_bad++; $display("FAIL rst_mid_resume got %0d want 10000", out_p); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_mac();
        test_wrap_saturate();
        test_cke_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
